// File: rtl/fir_filter_acc.sv
// Per-channel FIR accumulator: sums TAPS signed products, normalizes, clamps to 8 bits, emits RGB pixel.
// Build option: define FIR_ACC_ROUND_EN for round-half-up normalization (default truncates).
module fir_filter_acc #(
   parameter int unsigned TAPS  = 9,
   parameter int unsigned ACC_W = 21,
   parameter int unsigned SHIFT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mac_en,
   input  logic                mac_clr,
   input  logic signed [16:0]  filter_r,
   input  logic signed [16:0]  filter_g,
   input  logic signed [16:0]  filter_b,
   output logic                acc_ready,
   output logic [23:0]         pix_out,
   output logic                pix_valid,
   input  logic                out_ready,
   output logic [7:0]          tap_cnt,
   output logic                err_drop
);

   localparam int unsigned RW = ACC_W + 1;
`ifdef FIR_ACC_ROUND_EN
   localparam int unsigned RND = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
`endif

   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

   state_t                   state_q, state_nx;
   logic signed [ACC_W-1:0]  acc_r, acc_g, acc_b;
   logic signed [ACC_W-1:0]  sum_r, sum_g, sum_b;
   logic                     accept, last;

   assign sum_r  = acc_r + ACC_W'(filter_r);
   assign sum_g  = acc_g + ACC_W'(filter_g);
   assign sum_b  = acc_b + ACC_W'(filter_b);
   assign accept = mac_en && acc_ready;
   assign last   = accept && (tap_cnt == 8'(TAPS - 1));

   // One extra bit so the rounding offset cannot overflow a full-scale sum.
   function automatic logic [7:0] norm_clamp(input logic signed [ACC_W-1:0] sum);
      logic signed [RW-1:0] n;
`ifdef FIR_ACC_ROUND_EN
      n = (RW'(sum) + $signed(RW'(RND))) >>> SHIFT;
`else
      n = RW'(sum) >>> SHIFT;
`endif
      if (n[RW-1])
         return 8'd0;
      else if (n > $signed(RW'(255)))
         return 8'd255;
      else
         return n[7:0];
   endfunction

   // State register; acc_ready tracks "not in OUT" as a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_ready <= 1'b1;
      end else begin
         state_q   <= state_nx;
         acc_ready <= (state_nx != OUT);
      end
   end

   // Next-state logic; mac_clr overrides, and a same-cycle product restarts the window.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (last) state_nx = OUT; else if (accept) state_nx = ACCUM;
         ACCUM:   if (last) state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (mac_clr)
         state_nx = mac_en ? ACCUM : IDLE;
   end

   // Accumulators, tap count, output pixel and drop flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_r     <= '0;
         acc_g     <= '0;
         acc_b     <= '0;
         tap_cnt   <= 8'd0;
         pix_out   <= 24'd0;
         pix_valid <= 1'b0;
         err_drop  <= 1'b0;
      end else if (mac_clr) begin
         acc_r     <= mac_en ? ACC_W'(filter_r) : '0;
         acc_g     <= mac_en ? ACC_W'(filter_g) : '0;
         acc_b     <= mac_en ? ACC_W'(filter_b) : '0;
         tap_cnt   <= mac_en ? 8'd1 : 8'd0;
         pix_valid <= 1'b0;
         err_drop  <= 1'b0;
      end else begin
         if (mac_en && !acc_ready)
            err_drop <= 1'b1;
         if (state_q == OUT && out_ready)
            pix_valid <= 1'b0;
         if (last) begin
            pix_out   <= {norm_clamp(sum_r), norm_clamp(sum_g), norm_clamp(sum_b)};
            pix_valid <= 1'b1;
            acc_r     <= '0;
            acc_g     <= '0;
            acc_b     <= '0;
            tap_cnt   <= 8'd0;
         end else if (accept) begin
            acc_r     <= sum_r;
            acc_g     <= sum_g;
            acc_b     <= sum_b;
            tap_cnt   <= tap_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fir_filter_acc.sv
// Testbench for fir_filter_acc: queue-based reference model checked every cycle, plus literal pixel checks.
module tb_fir_filter_acc;

   localparam int unsigned TAPS  = 9;
   localparam int unsigned ACC_W = 21;
   localparam int unsigned SHIFT = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               mac_en = 1'b0, mac_clr = 1'b0, out_ready = 1'b0;
   logic signed [16:0] filter_r = '0, filter_g = '0, filter_b = '0;
   logic               acc_ready, pix_valid, err_drop;
   logic [23:0]        pix_out;
   logic [7:0]         tap_cnt;

   int n_checks = 0;
   int n_errors = 0;

   fir_filter_acc #(.TAPS(TAPS), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst_n(rst_n), .mac_en(mac_en), .mac_clr(mac_clr),
      .filter_r(filter_r), .filter_g(filter_g), .filter_b(filter_b),
      .acc_ready(acc_ready), .pix_out(pix_out), .pix_valid(pix_valid),
      .out_ready(out_ready), .tap_cnt(tap_cnt), .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: list of accepted products per channel; pixel computed from their plain sum.
   int        q_r[$], q_g[$], q_b[$];
   bit        m_out, m_err, started;
   bit [23:0] m_pix;

   function automatic int chan(input int q[$]);
      int s = 0;
      int n;
      foreach (q[i]) s += q[i];
`ifdef FIR_ACC_ROUND_EN
      if (SHIFT > 0) s += (1 << (SHIFT - 1));
`endif
      n = s >>> SHIFT;
      if (n < 0) return 0;
      if (n > 255) return 255;
      return n;
   endfunction

   task automatic push_products();
      q_r.push_back(int'(filter_r));
      q_g.push_back(int'(filter_g));
      q_b.push_back(int'(filter_b));
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         q_r.delete(); q_g.delete(); q_b.delete();
         m_out = 0; m_err = 0; m_pix = 24'd0; started = 1;
      end else if (mac_clr) begin
         q_r.delete(); q_g.delete(); q_b.delete();
         m_out = 0; m_err = 0;
         if (mac_en) push_products();
      end else if (m_out) begin
         if (mac_en) m_err = 1;
         if (out_ready) m_out = 0;
      end else if (mac_en) begin
         push_products();
         if (q_r.size() == TAPS) begin
            m_pix = {8'(chan(q_r)), 8'(chan(q_g)), 8'(chan(q_b))};
            m_out = 1;
            q_r.delete(); q_g.delete(); q_b.delete();
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         check("acc_ready", 32'(acc_ready), 32'(!m_out));
         check("pix_valid", 32'(pix_valid), 32'(m_out));
         check("pix_out",   32'(pix_out),   32'(m_pix));
         check("tap_cnt",   32'(tap_cnt),   32'(q_r.size()));
         check("err_drop",  32'(err_drop),  32'(m_err));
      end
   end

   task automatic drive(input bit rst_v, input bit en, input bit clr, input bit ordy,
                        input int r, input int g, input int b);
      @(negedge clk);
      rst_n = rst_v; mac_en = en; mac_clr = clr; out_ready = ordy;
      filter_r = 17'(r); filter_g = 17'(g); filter_b = 17'(b);
   endtask

   task automatic idle(input bit ordy);
      drive(1, 0, 0, ordy, 0, 0, 0);
   endtask

   task automatic burst(input int n, input int r, input int g, input int b);
      for (int i = 0; i < n; i++) drive(1, 1, 0, 0, r, g, b);
      idle(0);
   endtask

   // Bounded wait for a finished pixel, then pin both DUT and model to a hand value.
   task automatic expect_pix(input string name, input logic [23:0] exp);
      int k = 0;
      while (!pix_valid && k < 20) begin idle(0); k++; end
      #1;
      check({name, "_valid"}, 32'(pix_valid), 32'd1);
      check(name, 32'(pix_out), 32'(exp));
      check({name, "_model"}, 32'(m_pix), 32'(exp));
   endtask

   task automatic release_pix();
      idle(1);
      idle(0);
   endtask

   initial begin
      logic [23:0] t2_exp;
`ifdef FIR_ACC_ROUND_EN
      t2_exp = 24'h393939;
`else
      t2_exp = 24'h383838;
`endif
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      idle(0);
      #1;
      check("rst_ready", 32'(acc_ready), 32'd1);
      check("rst_pix",   32'(pix_out),   32'd0);

      // T1: nine products of 100
      burst(9, 100, 100, 100);
      expect_pix("t1", 24'h383838);
      release_pix();
      #1 check("t1_rel_ready", 32'(acc_ready), 32'd1);

      // T2: sum 904, rounding-dependent
      for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, 100, 100, 100);
      burst(1, 104, 104, 104);
      expect_pix("t2", t2_exp);
      release_pix();

      // T3: clamp low and high; T4: hold in OUT with a dropped product
      burst(9, -50, 2000, 0);
      expect_pix("t3", 24'h00FF00);
      idle(0);
      drive(1, 1, 0, 0, 300, 300, 300);
      idle(0); idle(0); idle(0);
      #1;
      check("t4_err",   32'(err_drop),  32'd1);
      check("t4_ready", 32'(acc_ready), 32'd0);
      check("t4_hold",  32'(pix_out),   32'h00FF00);
      release_pix();
      #1;
      check("t4_valid_clr", 32'(pix_valid), 32'd0);
      check("t4_ready_set", 32'(acc_ready), 32'd1);

      // T5: aborted window leaves no residue and clears err_drop
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 500, 500, 500);
      drive(1, 0, 1, 0, 0, 0, 0);
      burst(9, 100, 100, 100);
      expect_pix("t5", 24'h383838);
      check("t5_err", 32'(err_drop), 32'd0);
      release_pix();

      // mac_clr with mac_en: product becomes tap 1 (7 + 8*100 = 807 -> 50 either build)
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 900, 900, 900);
      drive(1, 1, 1, 0, 7, 7, 7);
      burst(8, 100, 100, 100);
      expect_pix("clr_en", 24'h323232);
      release_pix();

      // T6: reset mid-window and while in OUT
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 400, 400, 400);
      drive(0, 0, 0, 0, 0, 0, 0);
      idle(0);
      #1 check("t6_tap", 32'(tap_cnt), 32'd0);
      burst(9, 100, 100, 100);
      expect_pix("t6a", 24'h383838);
      drive(0, 0, 0, 0, 0, 0, 0);
      idle(0);
      #1;
      check("t6_valid", 32'(pix_valid), 32'd0);
      check("t6_pix",   32'(pix_out),   32'd0);
      burst(9, 100, 100, 100);
      expect_pix("t6b", 24'h383838);
      release_pix();
      idle(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
